// File: rtl/hub_arbiter_pkg.sv
// Shared hub definitions: cog count, field widths, operation encodings and
// small decode helpers used by the arbiter, its lock bank and the cogs.
package hub_arbiter_pkg;

    localparam int HUB_COGS   = 8;
    localparam int HUB_SLOT_W = 3;
    localparam int HUB_ADDR_W = 14;
    localparam int HUB_DATA_W = 32;
    localparam int HUB_WB_W   = 4;
    localparam int HUB_LOCKS  = 8;

    typedef enum logic [1:0] {
        OP_RD      = 2'b00,
        OP_WR      = 2'b01,
        OP_LOCKSET = 2'b10,
        OP_LOCKCLR = 2'b11
    } hub_op_e;

    typedef logic [HUB_SLOT_W-1:0] slot_t;

    // One-hot cog mask for a slot number.
    function automatic logic [HUB_COGS-1:0] slot_onehot(input slot_t s);
        slot_onehot = {{(HUB_COGS-1){1'b0}}, 1'b1} << s;
    endfunction

    // Both lock operations share the upper op bit.
    function automatic logic is_lock_op(input hub_op_e o);
        is_lock_op = o[1];
    endfunction

endpackage

// File: rtl/hub_arbiter_if.sv
// Hub bus bundle between the cogs, the arbiter and hub memory.
// Cog side  : req, op, wb, a, d (packed per cog), ack, rdata.
// Memory side: mem_w, mem_wb, mem_a, mem_d (to RAM), mem_q (from RAM).
// slave  modport: arbiter view.  master modport: cogs + memory view.
interface hub_arbiter_if;
    import hub_arbiter_pkg::*;

    logic [HUB_COGS-1:0]            req;
    logic [2*HUB_COGS-1:0]          op;
    logic [HUB_WB_W*HUB_COGS-1:0]   wb;
    logic [HUB_ADDR_W*HUB_COGS-1:0] a;
    logic [HUB_DATA_W*HUB_COGS-1:0] d;
    logic [HUB_COGS-1:0]            ack;
    logic [HUB_DATA_W-1:0]          rdata;

    logic                           mem_w;
    logic [HUB_WB_W-1:0]            mem_wb;
    logic [HUB_ADDR_W-1:0]          mem_a;
    logic [HUB_DATA_W-1:0]          mem_d;
    logic [HUB_DATA_W-1:0]          mem_q;

    modport slave (
        input  req, op, wb, a, d, mem_q,
        output ack, rdata, mem_w, mem_wb, mem_a, mem_d
    );

    modport master (
        output req, op, wb, a, d, mem_q,
        input  ack, rdata, mem_w, mem_wb, mem_a, mem_d
    );

endinterface

// File: rtl/hub_locks.sv
// Hub lock bank: eight semaphore bits plus the value a lock op found.
// Ports: clk_cog/nres clock and async active-low reset; lock_en_i performs a
//        lock op this edge; lock_set_i selects set (1) or clear (0);
//        lock_id_i lock index; lock_prev_o lock state before the last op.
module hub_locks
    import hub_arbiter_pkg::*;
(
    input  logic                          clk_cog,
    input  logic                          nres,
    input  logic                          lock_en_i,
    input  logic                          lock_set_i,
    input  logic [$clog2(HUB_LOCKS)-1:0]  lock_id_i,
    output logic                          lock_prev_o
);

    logic [HUB_LOCKS-1:0] lock_q;
    logic [HUB_LOCKS-1:0] lock_d;
    logic                 lock_prev_q;
    logic                 lock_prev_d;

    // Next lock state: sample the old bit, then set or clear it.
    always_comb begin
        lock_d      = lock_q;
        lock_prev_d = lock_prev_q;
        if (lock_en_i) begin
            lock_prev_d          = lock_q[lock_id_i];
            lock_d[lock_id_i]    = lock_set_i;
        end else begin
            lock_d      = lock_q;
            lock_prev_d = lock_prev_q;
        end
    end

    // Lock registers with asynchronous clear.
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            lock_q      <= {HUB_LOCKS{1'b0}};
            lock_prev_q <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            lock_prev_q <= lock_prev_d;
        end
    end

    assign lock_prev_o = lock_prev_q;

endmodule

// File: rtl/hub_arbiter.sv
// Round-robin hub arbiter: a free-running slot counter (advancing on
// ena_bus) gives each cog one hub access per eight slots. The selected
// cog's address/data/byte-enables go straight to hub memory; the served
// cog gets a one-cycle one-hot ack with read data or the prior lock state.
// Ports: clk_cog clock, nres async active-low reset, ena_bus slot strobe,
//        bus (slave modport) carrying cog requests, acks and memory port.
module hub_arbiter
    import hub_arbiter_pkg::*;
#(
    parameter int COGS = HUB_COGS
) (
    input  logic          clk_cog,
    input  logic          nres,
    input  logic          ena_bus,
    hub_arbiter_if.slave  bus
);

    // Per-cog views of the packed request fields.
    logic [1:0]            op_s [COGS];
    logic [HUB_WB_W-1:0]   wb_s [COGS];
    logic [HUB_ADDR_W-1:0] a_s  [COGS];
    logic [HUB_DATA_W-1:0] d_s  [COGS];

    for (genvar g = 0; g < COGS; g++) begin : g_split
        assign op_s[g] = bus.op[2*g +: 2];
        assign wb_s[g] = bus.wb[HUB_WB_W*g +: HUB_WB_W];
        assign a_s[g]  = bus.a[HUB_ADDR_W*g +: HUB_ADDR_W];
        assign d_s[g]  = bus.d[HUB_DATA_W*g +: HUB_DATA_W];
    end

    slot_t   slot_q, slot_d;
    logic    ack_valid_q, ack_valid_d;
    slot_t   ack_cog_q, ack_cog_d;
    logic    is_lock_q, is_lock_d;

    logic                  sel_req_s;
    hub_op_e               sel_op_s;
    logic [HUB_ADDR_W-1:0] sel_a_s;
    logic                  lock_en_s;
    logic                  lock_set_s;
    logic                  lock_prev_s;

    logic [COGS-1:0]       ack_s;
    logic [HUB_DATA_W-1:0] rdata_s;
    logic                  mem_w_s;

    // Request selected by the current slot.
    always_comb begin
        sel_req_s = bus.req[slot_q];
        sel_op_s  = hub_op_e'(op_s[slot_q]);
        sel_a_s   = a_s[slot_q];
    end

    // Lock ops act only when the owning cog is actually served.
    assign lock_en_s  = ena_bus & sel_req_s & is_lock_op(sel_op_s);
    assign lock_set_s = (sel_op_s == OP_LOCKSET);

    hub_locks u_locks (
        .clk_cog     (clk_cog),
        .nres        (nres),
        .lock_en_i   (lock_en_s),
        .lock_set_i  (lock_set_s),
        .lock_id_i   (sel_a_s[$clog2(HUB_LOCKS)-1:0]),
        .lock_prev_o (lock_prev_s)
    );

    // Slot/ack register stage.
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            slot_q      <= {HUB_SLOT_W{1'b0}};
            ack_valid_q <= 1'b0;
            ack_cog_q   <= {HUB_SLOT_W{1'b0}};
            is_lock_q   <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            ack_valid_q <= ack_valid_d;
            ack_cog_q   <= ack_cog_d;
            is_lock_q   <= is_lock_d;
        end
    end

    // Next state: the slot turns regardless of demand; ack_valid is a
    // single-cycle pulse, so it drops on any edge that does not serve.
    always_comb begin
        slot_d      = slot_q;
        ack_valid_d = 1'b0;
        ack_cog_d   = ack_cog_q;
        is_lock_d   = is_lock_q;
        if (ena_bus) begin
            slot_d = slot_q + 3'd1;
            if (sel_req_s) begin
                ack_valid_d = 1'b1;
                ack_cog_d   = slot_q;
                is_lock_d   = is_lock_op(sel_op_s);
            end else begin
                ack_valid_d = 1'b0;
            end
        end else begin
            slot_d      = slot_q;
            ack_valid_d = 1'b0;
        end
    end

    // Outputs: memory port follows the slot combinationally; the response
    // mux is gated so rdata is zero whenever no ack is presented.
    always_comb begin
        mem_w_s = sel_req_s & (sel_op_s == OP_WR);
        ack_s   = {COGS{1'b0}};
        rdata_s = {HUB_DATA_W{1'b0}};
        if (ack_valid_q) begin
            ack_s = slot_onehot(ack_cog_q);
            if (is_lock_q) begin
                rdata_s = {{(HUB_DATA_W-1){1'b0}}, lock_prev_s};
            end else begin
                rdata_s = bus.mem_q;
            end
        end else begin
            ack_s   = {COGS{1'b0}};
            rdata_s = {HUB_DATA_W{1'b0}};
        end
    end

    assign bus.mem_w  = mem_w_s;
    assign bus.mem_wb = wb_s[slot_q];
    assign bus.mem_a  = sel_a_s;
    assign bus.mem_d  = d_s[slot_q];
    assign bus.ack    = ack_s;
    assign bus.rdata  = rdata_s;

endmodule

// File: tb/tb_hub_arbiter.sv
// Bench for hub_arbiter: a small hub RAM, directed scenarios and a random
// phase, all checked against a slot/lock/memory reference model.
module tb_hub_arbiter;
    import hub_arbiter_pkg::*;

    logic clk_cog;
    logic nres;
    logic ena_bus;

    hub_arbiter_if bus ();

    hub_arbiter #(.COGS(HUB_COGS)) dut (
        .clk_cog (clk_cog),
        .nres    (nres),
        .ena_bus (ena_bus),
        .bus     (bus)
    );

    initial begin
        clk_cog = 1'b0;
        forever #5 clk_cog = ~clk_cog;
    end

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Hub RAM (32 words), writes clock-enabled by ena_bus, registered read.
    logic [31:0] ram [32];
    logic        pl_we;
    logic [4:0]  pl_a;
    logic [31:0] pl_d;

    always @(posedge clk_cog) begin
        if (pl_we) ram[pl_a] <= pl_d;
        else if (bus.mem_w && ena_bus)
            ram[bus.mem_a[4:0]] <= merge(ram[bus.mem_a[4:0]], bus.mem_d, bus.mem_wb);
        bus.mem_q <= ram[bus.mem_a[4:0]];
    end

    // Reference model state.
    int          m_slot;
    bit          m_lock [8];
    logic [31:0] m_mem [32];

    int n_asrt;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_cog(input int c, input logic r, input logic [1:0] o, input logic [3:0] w,
                           input logic [13:0] ad, input logic [31:0] dd);
        bus.req[c]         = r;
        bus.op[2*c +: 2]   = o;
        bus.wb[4*c +: 4]   = w;
        bus.a[14*c +: 14]  = ad;
        bus.d[32*c +: 32]  = dd;
    endtask

    // One clock: check the memory port, predict the edge, check the response.
    task automatic cyc(input logic en);
        int          s;
        int          id;
        logic [1:0]  o;
        logic [13:0] ad;
        logic [31:0] old_w;
        logic [7:0]  nexp_ack;
        logic [31:0] nexp_rd;
        ena_bus = en;
        #1;
        s = m_slot;
        chk("mem_a",  {18'd0, bus.mem_a},  {18'd0, bus.a[14*s +: 14]});
        chk("mem_d",  bus.mem_d,           bus.d[32*s +: 32]);
        chk("mem_wb", {28'd0, bus.mem_wb}, {28'd0, bus.wb[4*s +: 4]});
        chk("mem_w",  {31'd0, bus.mem_w},  {31'd0, (bus.req[s] && bus.op[2*s +: 2] == 2'b01)});
        nexp_ack = 8'd0;
        nexp_rd  = 32'd0;
        if (en) begin
            if (bus.req[s]) begin
                nexp_ack = 8'(1 << s);
                o        = bus.op[2*s +: 2];
                ad       = bus.a[14*s +: 14];
                old_w    = m_mem[ad[4:0]];
                case (o)
                    2'b00: nexp_rd = old_w;
                    2'b01: begin
                        nexp_rd         = old_w;
                        m_mem[ad[4:0]]  = merge(old_w, bus.d[32*s +: 32], bus.wb[4*s +: 4]);
                    end
                    default: begin
                        id         = int'(ad[2:0]);
                        nexp_rd    = {31'd0, m_lock[id]};
                        m_lock[id] = (o == 2'b10);
                    end
                endcase
            end
            m_slot = (m_slot + 1) % 8;
        end
        @(posedge clk_cog);
        #1;
        chk("ack",   {24'd0, bus.ack}, {24'd0, nexp_ack});
        chk("rdata", bus.rdata,        nexp_rd);
    endtask

    // Run until cog c is acked (bounded), then the cog drops its request.
    task automatic serve(input int c, output logic [31:0] rd, output logic [7:0] ackv, output int n);
        bit got;
        got  = 1'b0;
        rd   = 32'd0;
        ackv = 8'd0;
        n    = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            cyc(1'b1);
            n++;
            if (bus.ack[c] === 1'b1) begin
                got        = 1'b1;
                rd         = bus.rdata;
                ackv       = bus.ack;
                bus.req[c] = 1'b0;
            end
        end
        chk($sformatf("served_cog%0d", c), {31'd0, got}, 32'd1);
    endtask

    task automatic align(input int target);
        for (int k = 0; k < 8; k++) begin
            if (m_slot != target) cyc(1'b1);
        end
    endtask

    logic [31:0] rd;
    logic [7:0]  ackv;
    int          n;

    initial begin
        n_asrt   = 0;
        n_fail   = 0;
        nres     = 1'b1;
        ena_bus  = 1'b0;
        pl_we    = 1'b0;
        pl_a     = 5'd0;
        pl_d     = 32'd0;
        bus.req  = '0;
        bus.op   = '0;
        bus.wb   = '0;
        bus.a    = '0;
        bus.d    = '0;
        m_slot   = 0;
        for (int i = 0; i < 8; i++) m_lock[i] = 1'b0;
        for (int c = 0; c < 8; c++) set_cog(c, 1'b0, 2'b00, 4'(c), 14'(16'h0100 + c), $urandom);
        #1 nres = 1'b0;

        // Preload the RAM while reset is held.
        for (int i = 0; i < 32; i++) begin
            pl_we = 1'b1;
            pl_a  = 5'(i);
            pl_d  = (i == 16) ? 32'hDEADBEEF : ((i == 4) ? 32'hAABBCCDD : $urandom);
            m_mem[i] = pl_d;
            @(posedge clk_cog);
            #1;
        end
        pl_we = 1'b0;

        chk("rst_ack",   {24'd0, bus.ack},  32'd0);
        chk("rst_rdata", bus.rdata,         32'd0);
        chk("rst_mem_w", {31'd0, bus.mem_w}, 32'd0);
        chk("rst_slot0", {18'd0, bus.mem_a}, {18'd0, bus.a[13:0]});
        nres = 1'b1;

        // cog3 read of preloaded word.
        set_cog(3, 1'b1, 2'b00, 4'hF, 14'h0010, 32'd0);
        serve(3, rd, ackv, n);
        chk("rd3_ack",   {24'd0, ackv}, 32'h0000_0008);
        chk("rd3_rdata", rd,            32'hDEADBEEF);
        chk("rd3_wait",  32'(n),        32'd4);

        // cog0 partial write then readback.
        set_cog(0, 1'b1, 2'b01, 4'b0011, 14'h0004, 32'h12345678);
        serve(0, rd, ackv, n);
        chk("wr0_ack", {24'd0, ackv}, 32'h0000_0001);
        set_cog(0, 1'b1, 2'b00, 4'b0000, 14'h0004, 32'd0);
        serve(0, rd, ackv, n);
        chk("wr0_readback", rd, 32'hAABB5678);

        // Lock sequence on id 2.
        set_cog(5, 1'b1, 2'b10, 4'd0, 14'h0002, 32'd0);
        serve(5, rd, ackv, n);
        chk("lock5_set", rd, 32'd0);
        set_cog(6, 1'b1, 2'b10, 4'd0, 14'h0002, 32'd0);
        serve(6, rd, ackv, n);
        chk("lock6_set", rd, 32'd1);
        set_cog(5, 1'b1, 2'b11, 4'd0, 14'h0002, 32'd0);
        serve(5, rd, ackv, n);
        chk("lock5_clr", rd, 32'd1);
        set_cog(6, 1'b1, 2'b10, 4'd0, 14'h0002, 32'd0);
        serve(6, rd, ackv, n);
        chk("lock6_set2", rd, 32'd0);

        // All cogs requesting: strict rotation.
        align(0);
        for (int c = 0; c < 8; c++) set_cog(c, 1'b1, 2'b00, 4'd0, 14'($urandom_range(0, 31)), 32'd0);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1);
            chk($sformatf("fair_%0d", k), {24'd0, bus.ack}, {24'd0, 8'(1 << (k % 8))});
        end
        bus.req = '0;

        // ena_bus low: slot frozen on cog1, nothing served.
        align(1);
        set_cog(1, 1'b1, 2'b00, 4'd0, 14'h0007, 32'd0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0);
            chk("gate_ack",   {24'd0, bus.ack},  32'd0);
            chk("gate_mem_a", {18'd0, bus.mem_a}, 32'h0000_0007);
        end
        serve(1, rd, ackv, n);
        chk("gate_served_next", 32'(n), 32'd1);
        cyc(1'b0);

        // Random traffic.
        for (int it = 0; it < 300; it++) begin
            for (int c = 0; c < 8; c++) begin
                if (!bus.req[c] && $urandom_range(0, 3) == 0)
                    set_cog(c, 1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                            14'($urandom_range(0, 31)), $urandom);
            end
            cyc($urandom_range(0, 3) != 0);
            for (int c = 0; c < 8; c++) begin
                if (bus.ack[c]) bus.req[c] = 1'b0;
            end
        end

        // Reset while an ack is showing and lock 2 is held.
        bus.req = '0;
        set_cog(5, 1'b1, 2'b10, 4'd0, 14'h0002, 32'd0);
        serve(5, rd, ackv, n);
        chk("pre_rst_ack", {24'd0, bus.ack}, 32'h0000_0020);
        nres = 1'b0;
        #1;
        chk("mid_rst_ack",   {24'd0, bus.ack},   32'd0);
        chk("mid_rst_rdata", bus.rdata,          32'd0);
        chk("mid_rst_mem_w", {31'd0, bus.mem_w}, 32'd0);
        chk("mid_rst_slot0", {18'd0, bus.mem_a}, {18'd0, bus.a[13:0]});
        m_slot = 0;
        for (int i = 0; i < 8; i++) m_lock[i] = 1'b0;
        #1;
        nres = 1'b1;
        set_cog(6, 1'b1, 2'b10, 4'd0, 14'h0002, 32'd0);
        serve(6, rd, ackv, n);
        chk("post_rst_lock", rd,     32'd0);
        chk("post_rst_wait", 32'(n), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
